// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register
//
// Holds the program counter and the IF/ID register of a simple in-order
// pipeline. The PC is presented directly to instruction memory. Next-PC
// priority is jump > taken branch > sequential (PC+4 when memory is ready,
// otherwise hold). The hazard unit gates PC and IF/ID updates and can flush
// IF/ID with a bubble. A saturating counter records non-advancing fetch cycles.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   pcWrite      in   1   PC update enable (hazard unit)
//   IFIDWrite    in   1   IF/ID update enable (hazard unit)
//   ifNop        in   1   load a bubble into IF/ID
//   jump         in   1   jump redirect request
//   jumpTarget   in  32   jump destination
//   branchTaken  in   1   resolved branch taken
//   branchTarget in  32   branch destination
//   imemData     in  32   instruction word at imemAddr
//   imemReady    in   1   imemData valid this cycle
//   imemAddr     out 32   current PC (register output)
//   IDInst       out 32   IF/ID instruction
//   IDPCPlus4    out 32   IF/ID PC+4
//   IDValid      out  1   IF/ID holds a real instruction
//   stallCycles  out 16   saturating count of non-advancing fetch cycles
// -----------------------------------------------------------------------------
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcWrite,
  input  logic        IFIDWrite,
  input  logic        ifNop,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic [31:0] imemData,
  input  logic        imemReady,
  output logic [31:0] imemAddr,
  output logic [31:0] IDInst,
  output logic [31:0] IDPCPlus4,
  output logic        IDValid,
  output logic [15:0] stallCycles
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_q, stall_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        redirect_req;
  logic        redirect_load;
  logic        stall_event;

  always_comb begin
    pc_plus4      = pc_q + 32'd4;   // wraps modulo 2^32
    redirect_req  = jump | branchTaken;
    // Redirect targets are word aligned: low two bits forced to zero.
    redirect_tgt  = (jump ? jumpTarget : branchTarget) & ~32'd3;
    redirect_load = pcWrite & redirect_req;

    pc_d = pc_q;
    if (pcWrite) begin
      if (redirect_req)   pc_d = redirect_tgt;
      else if (imemReady) pc_d = pc_plus4;
    end

    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (IFIDWrite) begin
      if (!ifNop && imemReady) begin
        inst_d  = imemData;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end else begin
        inst_d  = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    end

    // A cycle counts as stalled when the PC does not advance and no redirect
    // was taken; loading a redirect is forward progress even without data.
    stall_event = !redirect_load && (!pcWrite || !imemReady);
    stall_d     = stall_q;
    if (stall_event && (stall_q != '1)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign imemAddr    = pc_q;
  assign IDInst      = inst_q;
  assign IDPCPlus4   = pc4_q;
  assign IDValid     = valid_q;
  assign stallCycles = stall_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// Vectors hold the inputs for one clock edge and the outputs required after
// that edge. Each applied vector is pushed to a scoreboard queue and popped
// once the edge has passed, then every output is compared.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, pcWrite, IFIDWrite, ifNop, jump, branchTaken, imemReady;
  logic [31:0] jumpTarget, branchTarget, imemData;
  logic [31:0] imemAddr, IDInst, IDPCPlus4;
  logic        IDValid;
  logic [15:0] stallCycles;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pcWrite      (pcWrite),
    .IFIDWrite    (IFIDWrite),
    .ifNop        (ifNop),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imemData     (imemData),
    .imemReady    (imemReady),
    .imemAddr     (imemAddr),
    .IDInst       (IDInst),
    .IDPCPlus4    (IDPCPlus4),
    .IDValid      (IDValid),
    .stallCycles  (stallCycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, pw, iw, nop, jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt, data;
    logic        rdy;
    logic [31:0] e_pc, e_inst, e_pc4;
    logic        e_valid;
    logic [15:0] e_stall;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(string name, logic r, logic pw, logic iw, logic nop,
                              logic jmp, logic [31:0] jt, logic br, logic [31:0] bt,
                              logic [31:0] data, logic rdy, logic [31:0] e_pc,
                              logic [31:0] e_inst, logic [31:0] e_pc4, logic e_valid,
                              logic [15:0] e_stall);
    vec_t v;
    v.name = name; v.rst = r; v.pw = pw; v.iw = iw; v.nop = nop; v.jmp = jmp;
    v.jt = jt; v.br = br; v.bt = bt; v.data = data; v.rdy = rdy;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(string name, string field, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
  endtask

  // Drive one vector, let one rising edge pass, then compare against the
  // scoreboard entry. When do_chk is 0 the entry is only consumed.
  task automatic apply(vec_t v, bit do_chk);
    vec_t e;
    @(negedge clk);
    rst = v.rst; pcWrite = v.pw; IFIDWrite = v.iw; ifNop = v.nop;
    jump = v.jmp; jumpTarget = v.jt; branchTaken = v.br; branchTarget = v.bt;
    imemData = v.data; imemReady = v.rdy;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (do_chk) begin
      chk(e.name, "imemAddr",    imemAddr,            e.e_pc);
      chk(e.name, "IDInst",      IDInst,              e.e_inst);
      chk(e.name, "IDPCPlus4",   IDPCPlus4,           e.e_pc4);
      chk(e.name, "IDValid",     {31'd0, IDValid},    {31'd0, e.e_valid});
      chk(e.name, "stallCycles", {16'd0, stallCycles}, {16'd0, e.e_stall});
    end
  endtask

  localparam logic [31:0] A = 32'h1111_1111, B = 32'h2222_2222, C = 32'h3333_3333;
  localparam logic [31:0] D = 32'h4444_4444, E = 32'h5555_5555, F = 32'h6666_6666;
  localparam logic [31:0] G = 32'h7777_7777, H = 32'h8888_8888, I = 32'h9999_9999;
  localparam logic [31:0] J = 32'hAAAA_AAAA, X = 32'hDEAD_BEEF;

  initial begin
    int unsigned exp_stall;
    rst = 1'b1; pcWrite = 1'b0; IFIDWrite = 1'b0; ifNop = 1'b0; jump = 1'b0;
    branchTaken = 1'b0; imemReady = 1'b0;
    jumpTarget = '0; branchTarget = '0; imemData = '0;

    //          name         rst pw iw nop jmp jt             br bt             data rdy  pc             inst pc4            v  stall
    tbl.push_back(mk("reset",     1, 1, 1, 0, 0, 32'h0,          0, 32'h0,          X, 1, 32'h0,         0, 32'h0,         0, 0));
    tbl.push_back(mk("seqA",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          A, 1, 32'h4,         A, 32'h4,         1, 0));
    tbl.push_back(mk("seqB",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          B, 1, 32'h8,         B, 32'h8,         1, 0));
    tbl.push_back(mk("loaduse",   0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          C, 1, 32'h8,         B, 32'h8,         1, 1));
    tbl.push_back(mk("seqC",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          C, 1, 32'hC,         C, 32'hC,         1, 1));
    tbl.push_back(mk("branch",    0, 1, 1, 1, 0, 32'h0,          1, 32'h40,         X, 1, 32'h40,        0, 32'h0,         0, 1));
    tbl.push_back(mk("seqD",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          D, 1, 32'h44,        D, 32'h44,        1, 1));
    tbl.push_back(mk("collide",   0, 1, 1, 1, 1, 32'h103,        1, 32'h80,         X, 1, 32'h100,       0, 32'h0,         0, 1));
    tbl.push_back(mk("seqE",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          E, 1, 32'h104,       E, 32'h104,       1, 1));
    tbl.push_back(mk("stallredir",0, 0, 0, 1, 1, 32'h200,        0, 32'h0,          X, 1, 32'h104,       E, 32'h104,       1, 2));
    tbl.push_back(mk("brnoready", 0, 1, 1, 0, 0, 32'h0,          1, 32'h23,         X, 0, 32'h20,        0, 32'h0,         0, 2));
    tbl.push_back(mk("wait1",     0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          X, 0, 32'h20,        0, 32'h0,         0, 3));
    tbl.push_back(mk("wait2",     0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          X, 0, 32'h20,        0, 32'h0,         0, 4));
    tbl.push_back(mk("seqF",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          F, 1, 32'h24,        F, 32'h24,        1, 4));
    tbl.push_back(mk("ifidhold",  0, 1, 0, 1, 0, 32'h0,          0, 32'h0,          G, 1, 32'h28,        F, 32'h24,        1, 4));
    tbl.push_back(mk("jumptop",   0, 1, 1, 0, 1, 32'hFFFF_FFFE,  0, 32'h0,          H, 1, 32'hFFFF_FFFC, H, 32'h2C,        1, 4));
    tbl.push_back(mk("wrap",      0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          I, 1, 32'h0,         I, 32'h0,         1, 4));
    tbl.push_back(mk("rstredir",  1, 1, 1, 0, 1, 32'h300,        1, 32'h400,        J, 1, 32'h0,         0, 32'h0,         0, 0));
    tbl.push_back(mk("postrst",   0, 1, 1, 0, 0, 32'h0,          0, 32'h0,          J, 1, 32'h4,         J, 32'h4,         1, 0));

    foreach (tbl[k]) apply(tbl[k], 1'b1);

    // Memory wait long enough to reach and hold saturation.
    exp_stall = 0;
    for (int unsigned k = 0; k < 65540; k++) begin
      if (exp_stall < 65535) exp_stall++;
      apply(mk("saturate", 0, 1, 1, 0, 0, 32'h0, 0, 32'h0, X, 0,
               32'h4, 32'h0, 32'h0, 1'b0, exp_stall[15:0]),
            (k < 3) || (k >= 65532));
    end

    // Reset in the middle of the wait clears everything; fetch resumes at 0.
    apply(mk("rstwait", 1, 1, 1, 0, 0, 32'h0, 0, 32'h0, X, 0, 32'h0, 0, 32'h0, 0, 0), 1'b1);
    apply(mk("firstfetch", 0, 1, 1, 0, 0, 32'h0, 0, 32'h0, A, 1, 32'h4, A, 32'h4, 1, 0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
